// File: rtl/multi_phase_tlc_if.sv
// Supervisor-side bundle for the N-phase traffic light controller: sensor and
// preempt requests in, per-phase lights plus status out.
interface multi_phase_tlc_if #(
  parameter int N_DIR = 3
);
  localparam int CH_W = $clog2(N_DIR);

  logic [N_DIR-1:0]   sensor;
  logic               preempt;
  logic [2*N_DIR-1:0] lights;
  logic [CH_W-1:0]    active_ch;
  logic [1:0]         phase;

  modport master (output sensor, preempt, input lights, active_ch, phase);
  modport slave  (input sensor, preempt, output lights, active_ch, phase);
endinterface

// File: rtl/multi_phase_tlc.sv
// N-phase round-robin traffic light controller: green ends on vacancy timeout,
// max-green under conflict or preempt; fixed yellow, then a minimum all-red.
module multi_phase_tlc #(
  parameter int N_DIR   = 3,
  parameter int VAC_CYC = 4,
  parameter int MAX_CYC = 9,
  parameter int YEL_CYC = 2,
  parameter int RED_CYC = 1
) (
  input logic              clk,
  input logic              reset,
  multi_phase_tlc_if.slave bus
);
  localparam int CH_W  = $clog2(N_DIR);
  localparam int LIM_A = (VAC_CYC > MAX_CYC) ? VAC_CYC : MAX_CYC;
  localparam int LIM_B = (YEL_CYC > RED_CYC) ? YEL_CYC : RED_CYC;
  localparam int CNT_W = $clog2(((LIM_A > LIM_B) ? LIM_A : LIM_B) + 1);

  localparam logic [CNT_W-1:0] VAC_LIM  = CNT_W'(VAC_CYC);
  localparam logic [CNT_W-1:0] MAX_LIM  = CNT_W'(MAX_CYC);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL_CYC - 1);
  localparam logic [CNT_W-1:0] RED_LIM  = CNT_W'(RED_CYC);
  // The cycle in which red_cnt==RED_CYC-1 is the RED_CYC-th all-red cycle.
  localparam logic [CNT_W-1:0] RED_GO   = CNT_W'(RED_CYC - 1);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_t;

  state_t           state;
  logic [CH_W-1:0]  active_ch;
  logic [CNT_W-1:0] red_cnt, vac_cnt, max_cnt, yel_cnt;

  logic             grant_ok;
  logic [CH_W-1:0]  grant_ch;
  logic [CH_W-1:0]  scan_ch;
  logic [N_DIR-1:0] others;
  logic             cur_req, conflict, green_done;

  // Scan furthest offset first so the nearest requester after active_ch wins;
  // offset N_DIR wraps back to active_ch itself, re-granting a lone requester.
  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    grant_ok = 1'b0;
    grant_ch = active_ch;
    scan_ch  = active_ch;
    for (int i = N_DIR; i >= 1; i--) begin
      scan_ch = (int'(active_ch) + i >= N_DIR) ? CH_W'(int'(active_ch) + i - N_DIR)
                                               : CH_W'(int'(active_ch) + i);
      if (bus.sensor[scan_ch]) begin
        grant_ok = 1'b1;
        grant_ch = scan_ch;
      end
    end
  end

  always_comb begin
    others            = bus.sensor;
    others[active_ch] = 1'b0;
  end

  assign cur_req    = bus.sensor[active_ch];
  assign conflict   = cur_req && (|others);
  assign green_done = (vac_cnt >= VAC_LIM) || (max_cnt >= MAX_LIM) || bus.preempt;

  // NOTE: all state updates use non-blocking assignments so every test sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ALLRED;
      active_ch <= CH_W'(N_DIR - 1);
      red_cnt   <= '0;
      vac_cnt   <= '0;
      max_cnt   <= '0;
      yel_cnt   <= '0;
    end else begin
      case (state)
        ST_ALLRED: begin
          if (red_cnt >= RED_GO && !bus.preempt && grant_ok) begin
            state     <= ST_GREEN;
            active_ch <= grant_ch;
          end else if (red_cnt < RED_LIM) begin
            red_cnt <= red_cnt + 1'b1;
          end
        end
        ST_GREEN: begin
          if (green_done) begin
            state   <= ST_YELLOW;
            vac_cnt <= '0;
            max_cnt <= '0;
            yel_cnt <= '0;
          end else begin
            // Both timers are sticky once started.
            if (!cur_req || vac_cnt != '0) vac_cnt <= vac_cnt + 1'b1;
            if (conflict || max_cnt != '0) max_cnt <= max_cnt + 1'b1;
          end
        end
        ST_YELLOW: begin
          if (yel_cnt == YEL_LAST) begin
            state   <= ST_ALLRED;
            yel_cnt <= '0;
            red_cnt <= '0;
          end else begin
            yel_cnt <= yel_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_ALLRED;
          red_cnt <= '0;
          vac_cnt <= '0;
          max_cnt <= '0;
          yel_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.lights = '0;
    bus.phase  = 2'b00;
    case (state)
      ST_GREEN: begin
        bus.lights[2*active_ch +: 2] = 2'b10;
        bus.phase                    = 2'b01;
      end
      ST_YELLOW: begin
        bus.lights[2*active_ch +: 2] = 2'b01;
        bus.phase                    = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.active_ch = active_ch;
endmodule

// File: tb/tb_multi_phase_tlc.sv
// Scoreboard bench for multi_phase_tlc: a default 3-phase instance and a
// 5-phase variant with shorter vacancy, longer yellow and longer all-red.
module tb_multi_phase_tlc;
  logic       clk = 1'b0;
  logic       reset;
  logic       preempt;
  logic [4:0] sensor;

  always #5 clk = ~clk;

  multi_phase_tlc_if #(.N_DIR(3)) bus_a ();
  multi_phase_tlc_if #(.N_DIR(5)) bus_b ();

  assign bus_a.sensor  = sensor[2:0];
  assign bus_a.preempt = preempt;
  assign bus_b.sensor  = sensor;
  assign bus_b.preempt = preempt;

  multi_phase_tlc #(.N_DIR(3), .VAC_CYC(4), .MAX_CYC(9), .YEL_CYC(2), .RED_CYC(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  multi_phase_tlc #(.N_DIR(5), .VAC_CYC(2), .MAX_CYC(9), .YEL_CYC(3), .RED_CYC(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  typedef struct packed {
    logic [9:0] lights;
    logic [1:0] phase;
    logic [2:0] ch;
  } obs_t;

  localparam logic [1:0] PH_RED = 2'b00;
  localparam logic [1:0] PH_GRN = 2'b01;
  localparam logic [1:0] PH_YEL = 2'b10;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   sel, n_dir, vac_c, max_c, yel_c, red_c;

  task automatic configure(input int s);
    sel = s;
    if (s == 0) begin
      n_dir = 3; vac_c = 4; max_c = 9; yel_c = 2; red_c = 1;
    end else begin
      n_dir = 5; vac_c = 2; max_c = 9; yel_c = 3; red_c = 2;
    end
  endtask

  task automatic push(input int n, input logic [1:0] ph, input int ch);
    obs_t e;
    e.phase  = ph;
    e.ch     = 3'(ch);
    e.lights = '0;
    if (ph == PH_GRN) e.lights = 10'(2'b10) << (2 * ch);
    if (ph == PH_YEL) e.lights = 10'(2'b01) << (2 * ch);
    repeat (n) sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic get_obs(output obs_t o);
    @(negedge clk);
    if (sel == 0) o = '{lights: 10'(bus_a.lights), phase: bus_a.phase, ch: 3'(bus_a.active_ch)};
    else          o = '{lights: bus_b.lights, phase: bus_b.phase, ch: bus_b.active_ch};
  endtask

  task automatic test_reset_idle();
    obs_t o, e;
    int   total;
    sensor = '0; preempt = 1'b0;
    do_reset();
    push(50, PH_RED, n_dir - 1);
    total = sb.size();
    for (int i = 0; i < total; i++) begin
      get_obs(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_idle[%0d] cyc %0d: got l=%b p=%b ch=%0d want l=%b p=%b ch=%0d",
                 sel, i, o.lights, o.phase, o.ch, e.lights, e.phase, e.ch);
      end
      tick();
    end
  endtask

  task automatic test_single();
    obs_t o, e;
    int   total;
    sensor = 5'b00010; preempt = 1'b0;
    do_reset();
    push(red_c, PH_RED, n_dir - 1);
    push(2 + vac_c + 1, PH_GRN, 1);
    push(yel_c, PH_YEL, 1);
    push(red_c + 3, PH_RED, 1);
    total = sb.size();
    for (int i = 0; i < total; i++) begin
      sensor = (i < red_c + 2) ? 5'b00010 : 5'b00000;
      get_obs(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL single[%0d] cyc %0d: got l=%b p=%b ch=%0d want l=%b p=%b ch=%0d",
                 sel, i, o.lights, o.phase, o.ch, e.lights, e.phase, e.ch);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    obs_t o, e;
    int   total;
    sensor = 5'b11111; preempt = 1'b0;
    do_reset();
    push(red_c, PH_RED, n_dir - 1);
    for (int k = 0; k < 4; k++) begin
      push(max_c + 1, PH_GRN, k % n_dir);
      push(yel_c, PH_YEL, k % n_dir);
      push(red_c, PH_RED, k % n_dir);
    end
    total = sb.size();
    for (int i = 0; i < total; i++) begin
      get_obs(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL round_robin[%0d] cyc %0d: got l=%b p=%b ch=%0d want l=%b p=%b ch=%0d",
                 sel, i, o.lights, o.phase, o.ch, e.lights, e.phase, e.ch);
      end
      tick();
    end
  endtask

  task automatic test_preempt();
    obs_t o, e;
    int   total, r0;
    sensor = 5'b00111; preempt = 1'b0;
    do_reset();
    r0 = red_c + 3 + yel_c;
    push(red_c, PH_RED, n_dir - 1);
    push(3, PH_GRN, 0);
    push(yel_c, PH_YEL, 0);
    push(6, PH_RED, 0);
    push(3, PH_GRN, 1);
    total = sb.size();
    for (int i = 0; i < total; i++) begin
      preempt = (i >= red_c + 2 && i < r0 + 5);
      get_obs(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL preempt[%0d] cyc %0d: got l=%b p=%b ch=%0d want l=%b p=%b ch=%0d",
                 sel, i, o.lights, o.phase, o.ch, e.lights, e.phase, e.ch);
      end
      tick();
    end
    preempt = 1'b0;
  endtask

  task automatic test_sticky_vac();
    obs_t o, e;
    int   total;
    sensor = 5'b00100; preempt = 1'b0;
    do_reset();
    push(red_c, PH_RED, n_dir - 1);
    push(2 + vac_c + 1, PH_GRN, 2);
    push(yel_c, PH_YEL, 2);
    push(red_c, PH_RED, 2);
    push(2, PH_GRN, 2);
    total = sb.size();
    for (int i = 0; i < total; i++) begin
      sensor = (i == red_c + 2) ? 5'b00000 : 5'b00100;
      get_obs(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL sticky_vac[%0d] cyc %0d: got l=%b p=%b ch=%0d want l=%b p=%b ch=%0d",
                 sel, i, o.lights, o.phase, o.ch, e.lights, e.phase, e.ch);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    int   total, y0;
    sensor = 5'b00010; preempt = 1'b0;
    do_reset();
    y0 = red_c + vac_c + 1;
    push(red_c, PH_RED, n_dir - 1);
    push(vac_c + 1, PH_GRN, 1);
    push(1, PH_YEL, 1);
    push(red_c, PH_RED, n_dir - 1);
    push(2, PH_GRN, 0);
    total = sb.size();
    for (int i = 0; i < total; i++) begin
      sensor = (i < red_c) ? 5'b00010 : (i <= y0) ? 5'b00000 : 5'b00011;
      reset  = (i == y0);
      get_obs(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid[%0d] cyc %0d: got l=%b p=%b ch=%0d want l=%b p=%b ch=%0d",
                 sel, i, o.lights, o.phase, o.ch, e.lights, e.phase, e.ch);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    preempt = 1'b0;
    sensor  = '0;
    configure(0);
    tick();
    test_reset_idle();
    test_single();
    test_round_robin();
    test_preempt();
    test_sticky_vac();
    test_reset_mid();
    configure(1);
    test_reset_idle();
    test_single();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
